// File: rtl/int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : int_ctrl_pkg
//  Description : Shared constants for the interrupt controller: register
//                indices, TCTRL bit positions, timer line index and the
//                interrupt vector width.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package int_ctrl_pkg;

   localparam int W_INT      = 6;   // width of the vector fed to CP0 Cause.IP[7:2]
   localparam int TIMER_LINE = 5;   // compare timer occupies the top line

   localparam logic [2:0] REG_IMASK  = 3'd0;
   localparam logic [2:0] REG_IPEND  = 3'd1;
   localparam logic [2:0] REG_IMODE  = 3'd2;
   localparam logic [2:0] REG_TCOUNT = 3'd3;
   localparam logic [2:0] REG_TCMP   = 3'd4;
   localparam logic [2:0] REG_TCTRL  = 3'd5;

   localparam int TCTRL_EN  = 0;    // count enable
   localparam int TCTRL_PER = 1;    // reload to zero on match

endpackage
`default_nettype wire

// File: rtl/int_ctrl_irq_sync.sv
`default_nettype none
// ============================================================================
//  Module      : irq_sync
//  Description : Two-flop synchronizer for one asynchronous request line,
//                followed by a history flop for rising-edge detection.
//  Ports       : clk     - system clock
//                rst_    - asynchronous active-low reset
//                irq_raw - asynchronous request, active-high
//                lvl     - synchronized level (sync2)
//                rise    - one-cycle pulse on a synchronized rising edge
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_sync
   import int_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst_,
   input  logic irq_raw,
   output logic lvl,
   output logic rise
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= irq_raw;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign lvl  = r_sync2;
   assign rise = r_sync2 & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : int_ctrl
//  Description : Interrupt controller producing the 6-bit hardware interrupt
//                vector for CP0. Five external lines (edge or level) plus a
//                compare timer on the top line, each with pending latch and
//                mask, configured over a single-cycle register port.
//  Ports       : clk       - system clock
//                rst_      - asynchronous active-low reset
//                irq_raw   - external requests, asynchronous, active-high
//                bus_req   - register access request (single-cycle pulse)
//                bus_we    - 1 = write, 0 = read
//                bus_addr  - register index
//                bus_wdata - write data
//                bus_rdata - registered read data, held until the next read
//                bus_ack   - access done, one cycle after bus_req
//                int_o     - registered masked pending vector
//  Revision    : 1.0 - initial release
// ============================================================================
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int N_EXT = 5,
   parameter int CNT_W = 32
)(
   input  logic             clk,
   input  logic             rst_,
   input  logic [N_EXT-1:0] irq_raw,
   input  logic             bus_req,
   input  logic             bus_we,
   input  logic [2:0]       bus_addr,
   input  logic [31:0]      bus_wdata,
   output logic [31:0]      bus_rdata,
   output logic             bus_ack,
   output logic [W_INT-1:0] int_o
);

   localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [W_INT-1:0]      r_mask;
   logic [W_INT-1:0]      r_pend;
   logic [TIMER_LINE-1:0] r_mode;
   logic [CNT_W-1:0]      r_count;
   logic [CNT_W-1:0]      r_cmp;
   logic [1:0]            r_tctrl;
   logic [31:0]           r_rdata;
   logic                  r_ack;
   logic [W_INT-1:0]      r_int;

   logic [TIMER_LINE-1:0] w_lvl;
   logic [TIMER_LINE-1:0] w_rise;
   logic                  w_wr;
   logic                  w_rd;
   logic [W_INT-1:0]      w_w1c;
   logic                  w_cmp_wr;
   logic                  w_match;
   logic [W_INT-1:0]      w_pend_nxt;
   logic [CNT_W-1:0]      w_count_nxt;
   logic [31:0]           w_rdata_mux;

   // External lines; unpopulated positions below the timer line read as idle.
   genvar gi;
   generate
      for (gi = 0; gi < TIMER_LINE; gi++) begin : g_line
         if (gi < N_EXT) begin : g_ext
            irq_sync u_sync (
               .clk     (clk),
               .rst_    (rst_),
               .irq_raw (irq_raw[gi]),
               .lvl     (w_lvl[gi]),
               .rise    (w_rise[gi])
            );
         end else begin : g_none
            assign w_lvl[gi]  = 1'b0;
            assign w_rise[gi] = 1'b0;
         end
      end
   endgenerate

   assign w_wr     = bus_req & bus_we;
   assign w_rd     = bus_req & ~bus_we;
   assign w_w1c    = (w_wr && bus_addr == REG_IPEND) ? bus_wdata[W_INT-1:0] : '0;
   assign w_cmp_wr = w_wr && (bus_addr == REG_TCMP);
   assign w_match  = r_tctrl[TCTRL_EN] && (r_count == r_cmp);

   // Pending next state. A hardware set always wins over a W1C on the same
   // bit; level lines simply track the synchronized input and ignore W1C.
   always_comb begin
      w_pend_nxt = r_pend;
      for (int i = 0; i < TIMER_LINE; i++) begin
         if (r_mode[i])
            w_pend_nxt[i] = w_rise[i] | (r_pend[i] & ~w_w1c[i]);
         else
            w_pend_nxt[i] = w_lvl[i];
      end
      // Rewriting the compare value retires the old match, even one that
      // is being detected this very cycle.
      if (w_cmp_wr)
         w_pend_nxt[TIMER_LINE] = 1'b0;
      else if (w_match)
         w_pend_nxt[TIMER_LINE] = 1'b1;
      else if (w_w1c[TIMER_LINE])
         w_pend_nxt[TIMER_LINE] = 1'b0;
   end

   // A software write to TCOUNT overrides both increment and reload.
   always_comb begin
      w_count_nxt = r_count;
      if (w_wr && bus_addr == REG_TCOUNT)
         w_count_nxt = bus_wdata[CNT_W-1:0];
      else if (r_tctrl[TCTRL_EN]) begin
         if (w_match && r_tctrl[TCTRL_PER])
            w_count_nxt = '0;
         else
            w_count_nxt = r_count + c_cnt_one;
      end
   end

   always_comb begin
      w_rdata_mux = 32'h0;
      case (bus_addr)
         REG_IMASK:  w_rdata_mux = 32'(r_mask);
         REG_IPEND:  w_rdata_mux = 32'(r_pend);
         REG_IMODE:  w_rdata_mux = 32'(r_mode);
         REG_TCOUNT: w_rdata_mux = 32'(r_count);
         REG_TCMP:   w_rdata_mux = 32'(r_cmp);
         REG_TCTRL:  w_rdata_mux = 32'(r_tctrl);
         default:    w_rdata_mux = 32'h0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         r_mask  <= '0;
         r_pend  <= '0;
         r_mode  <= '0;
         r_count <= '0;
         r_cmp   <= '0;
         r_tctrl <= '0;
         r_rdata <= '0;
         r_ack   <= 1'b0;
         r_int   <= '0;
      end else begin
         r_ack   <= bus_req;
         r_pend  <= w_pend_nxt;
         r_count <= w_count_nxt;
         r_int   <= r_pend & r_mask;
         // Sampled with non-blocking semantics, so a read returns the
         // register contents from before this edge.
         if (w_rd)
            r_rdata <= w_rdata_mux;
         if (w_wr) begin
            case (bus_addr)
               REG_IMASK: r_mask  <= bus_wdata[W_INT-1:0];
               REG_IMODE: r_mode  <= bus_wdata[TIMER_LINE-1:0];
               REG_TCMP:  r_cmp   <= bus_wdata[CNT_W-1:0];
               REG_TCTRL: r_tctrl <= bus_wdata[1:0];
               default: ;
            endcase
         end
      end
   end

   assign bus_rdata = r_rdata;
   assign bus_ack   = r_ack;
   assign int_o     = r_int;

endmodule
`default_nettype wire

// File: tb/tb_int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_ctrl
//  Description : Self-checking bench for int_ctrl. Register accesses push
//                their expected acknowledge/read data into a queue that a
//                monitor drains when the DUT acknowledges.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_int_ctrl;
   import int_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_;
   logic [4:0]  irq_raw;
   logic        bus_req;
   logic        bus_we;
   logic [2:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic [5:0]  int_o;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   typedef struct {
      logic        rd;
      logic [2:0]  addr;
      logic [31:0] exp;
      int          due;
   } sb_t;
   sb_t sb[$];

   typedef struct {
      logic        we;
      logic [2:0]  addr;
      logic [31:0] data;   // write data, or expected read data
   } vec_t;
   vec_t vt[16];

   int_ctrl #(.N_EXT(5), .CNT_W(32)) dut (
      .clk       (clk),
      .rst_      (rst_),
      .irq_raw   (irq_raw),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_ack   (bus_ack),
      .int_o     (int_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic cyc_wait(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_access(input logic we, input logic [2:0] a, input logic [31:0] d);
      sb_t e;
      e.rd   = ~we;
      e.addr = a;
      e.exp  = we ? 32'h0 : d;
      e.due  = cyc + 1;
      sb.push_back(e);
      bus_req   = 1'b1;
      bus_we    = we;
      bus_addr  = a;
      bus_wdata = we ? d : 32'h0;
      @(posedge clk);
      #1;
      bus_req = 1'b0;
      bus_we  = 1'b0;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      bus_access(1'b1, a, d);
   endtask

   task automatic bus_read(input logic [2:0] a, input logic [31:0] exp);
      bus_access(1'b0, a, exp);
   endtask

   // Scoreboard monitor: every access must be acknowledged exactly one cycle
   // after it is sampled, and reads must return the queued value.
   initial begin
      sb_t e;
      forever begin
         @(posedge clk);
         #2;
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            checks++;
            if (bus_ack !== 1'b1) begin
               errors++;
               $display("FAIL bus_ack addr=%0d got=%b exp=1", e.addr, bus_ack);
            end else if (e.rd && bus_rdata !== e.exp) begin
               errors++;
               $display("FAIL bus_read addr=%0d got=%h exp=%h", e.addr, bus_rdata, e.exp);
            end
         end else if (bus_ack !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL bus_ack_spurious got=%b exp=0", bus_ack);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_      = 1'b0;
      irq_raw   = '0;
      bus_req   = 1'b0;
      bus_we    = 1'b0;
      bus_addr  = '0;
      bus_wdata = '0;

      vt[0]  = '{1'b1, REG_TCTRL,  32'h0};
      vt[1]  = '{1'b1, REG_IMASK,  32'hFFFF_FFFF};
      vt[2]  = '{1'b0, REG_IMASK,  32'h0000_003F};
      vt[3]  = '{1'b1, REG_IMODE,  32'hFFFF_FFFF};
      vt[4]  = '{1'b0, REG_IMODE,  32'h0000_001F};
      vt[5]  = '{1'b1, REG_TCMP,   32'hDEAD_BEEF};
      vt[6]  = '{1'b0, REG_TCMP,   32'hDEAD_BEEF};
      vt[7]  = '{1'b1, REG_TCOUNT, 32'h1234_5678};
      vt[8]  = '{1'b0, REG_TCOUNT, 32'h1234_5678};
      vt[9]  = '{1'b1, 3'd6,       32'hFFFF_FFFF};
      vt[10] = '{1'b0, 3'd6,       32'h0};
      vt[11] = '{1'b0, 3'd7,       32'h0};
      vt[12] = '{1'b1, REG_TCTRL,  32'hFFFF_FFFF};
      vt[13] = '{1'b0, REG_TCTRL,  32'h0000_0003};
      vt[14] = '{1'b1, REG_TCTRL,  32'h0};
      vt[15] = '{1'b0, REG_IMASK,  32'h0000_003F};

      cyc_wait(2);
      rst_ = 1'b1;
      cyc_wait(1);

      // Reset state
      chk("rst_int_o", {26'h0, int_o}, 32'h0);
      chk("rst_ack", {31'h0, bus_ack}, 32'h0);
      chk("rst_rdata", bus_rdata, 32'h0);
      bus_read(REG_IMASK, 32'h0);

      // Register table, issued back to back
      for (int i = 0; i < 16; i++)
         bus_access(vt[i].we, vt[i].addr, vt[i].data);

      // Level line
      bus_write(REG_IMODE, 32'h0);
      cyc_wait(4);
      irq_raw[2] = 1'b1;
      cyc_wait(3);
      chk("lvl_rise_early", {26'h0, int_o}, 32'h0);
      cyc_wait(1);
      chk("lvl_rise", {26'h0, int_o}, 32'h04);
      bus_write(REG_IPEND, 32'h04);
      bus_read(REG_IPEND, 32'h04);
      chk("lvl_w1c_noeffect", {26'h0, int_o}, 32'h04);
      irq_raw[2] = 1'b0;
      cyc_wait(3);
      chk("lvl_fall_early", {26'h0, int_o}, 32'h04);
      cyc_wait(1);
      chk("lvl_fall", {26'h0, int_o}, 32'h0);

      // Edge line
      bus_write(REG_IMODE, 32'h01);
      irq_raw[0] = 1'b1;
      cyc_wait(3);
      irq_raw[0] = 1'b0;
      cyc_wait(4);
      bus_read(REG_IPEND, 32'h01);
      chk("edge_sticky_int", {26'h0, int_o}, 32'h01);
      bus_write(REG_IPEND, 32'h01);
      bus_read(REG_IPEND, 32'h0);
      chk("edge_cleared_int", {26'h0, int_o}, 32'h0);
      irq_raw[0] = 1'b1;
      cyc_wait(2);
      bus_write(REG_IPEND, 32'h01);   // lands on the same edge as the set
      bus_read(REG_IPEND, 32'h01);
      irq_raw[0] = 1'b0;
      cyc_wait(3);
      bus_write(REG_IPEND, 32'h01);
      bus_read(REG_IPEND, 32'h0);

      // Timer one-shot
      bus_write(REG_IMASK, 32'h20);
      bus_write(REG_TCMP, 32'd10);
      bus_write(REG_TCOUNT, 32'd0);
      bus_write(REG_TCTRL, 32'd1);    // cycle 0, TCOUNT = 0
      bus_read(REG_TCOUNT, 32'd0);
      cyc_wait(9);                    // cycle 10: match cycle
      bus_read(REG_IPEND, 32'h0);
      chk("tmr_int_c1", {26'h0, int_o}, 32'h0);
      bus_read(REG_IPEND, 32'h20);
      chk("tmr_int_c2", {26'h0, int_o}, 32'h20);
      bus_read(REG_TCOUNT, 32'd12);
      bus_write(REG_TCMP, 32'd1000);
      bus_read(REG_IPEND, 32'h0);
      chk("tmr_cmp_clear_int", {26'h0, int_o}, 32'h0);
      bus_write(REG_TCTRL, 32'd0);

      // TCMP write on the match cycle suppresses the set
      bus_write(REG_TCOUNT, 32'd0);
      bus_write(REG_TCMP, 32'd5);
      bus_write(REG_TCTRL, 32'd1);
      cyc_wait(5);
      bus_write(REG_TCMP, 32'h100);
      bus_read(REG_IPEND, 32'h0);
      bus_write(REG_TCTRL, 32'd0);

      // Timer periodic
      bus_write(REG_TCOUNT, 32'd0);
      bus_write(REG_TCMP, 32'd4);
      bus_write(REG_TCTRL, 32'd3);    // cycle 0
      for (int k = 0; k < 12; k++)
         bus_read(REG_TCOUNT, 32'(k % 5));
      bus_write(REG_IPEND, 32'h20);   // cycle 12, count 2
      bus_read(REG_IPEND, 32'h0);
      bus_read(REG_IPEND, 32'h0);     // cycle 14 is the next match
      bus_read(REG_IPEND, 32'h20);
      bus_write(REG_TCTRL, 32'd0);

      // Timer wrap, PER = 0
      bus_write(REG_TCMP, 32'd2);
      bus_write(REG_TCOUNT, 32'hFFFF_FFFF);
      bus_write(REG_TCTRL, 32'd1);
      bus_read(REG_TCOUNT, 32'hFFFF_FFFF);
      bus_read(REG_TCOUNT, 32'h0);
      bus_read(REG_IPEND, 32'h0);
      bus_read(REG_IPEND, 32'h0);
      bus_read(REG_IPEND, 32'h20);
      bus_write(REG_TCTRL, 32'd0);

      // Asynchronous reset mid-cycle with int_o and an ack in flight
      bus_write(REG_IPEND, 32'h20);
      bus_write(REG_IMODE, 32'h0);
      bus_write(REG_IMASK, 32'h3F);
      irq_raw[0] = 1'b1;
      cyc_wait(5);
      chk("pre_rst_int", {26'h0, int_o}, 32'h01);
      bus_read(REG_IMASK, 32'h3F);
      #3;
      rst_ = 1'b0;
      #1;
      chk("async_rst_int", {26'h0, int_o}, 32'h0);
      chk("async_rst_ack", {31'h0, bus_ack}, 32'h0);
      chk("async_rst_rdata", bus_rdata, 32'h0);
      irq_raw = '0;
      #2;
      rst_ = 1'b1;
      cyc_wait(1);
      bus_read(REG_IMASK, 32'h0);

      cyc_wait(3);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain got=%0d exp=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/int_ctrl.md
# int_ctrl

- Interrupt controller that produces the 6-bit hardware-interrupt vector consumed by CP0 as Cause.IP[7:2].
- Sources: five asynchronous external request lines, plus an internal 32-bit compare timer on the top line.
- Each line passes through synchronization, then edge/level qualification, then a pending latch and a mask.
- Software configures and acknowledges lines through a small register port on the uncached peripheral bus.

## Interface
Parameters:
- N_EXT, 5, number of external request lines; mapped to int_o[N_EXT-1:0], timer on int_o[5]
- CNT_W, 32, timer counter and compare width

Ports:
- clk  in  1  system clock
- rst_  in  1  reset; asynchronous, active-low
- irq_raw  in  N_EXT  external requests, asynchronous to clk, active-high
- bus_req  in  1  register access request, single-cycle pulse
- bus_we  in  1  1 = write, 0 = read
- bus_addr  in  3  register index
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data, registered
- bus_ack  out  1  access done, one cycle after bus_req
- int_o  out  6  masked pending interrupts to CP0 int_i, registered

## Operation
Registers, by bus_addr:
- 0 IMASK[5:0]: rw; 1 = line enabled.
- 1 IPEND[5:0]: read returns raw pending; a write clears the bits where wdata is 1 (W1C). W1C affects only edge-mode lines and bit 5.
- 2 IMODE[4:0]: rw; 1 = edge, 0 = level. The timer line is always edge/sticky.
- 3 TCOUNT: rw.
- 4 TCMP: rw. Any write to TCMP also clears IPEND[5].
- 5 TCTRL: rw. Bit0 EN = count enable; bit1 PER = 1 makes TCOUNT reload to 0 on match.
- 6, 7: reads return 0; writes are ignored; bus_ack is still returned.

Per-line datapath:
- irq_raw goes through sync1, then sync2, then prev.
- Level mode: pend follows sync2 every cycle.
- Edge mode: pend is set when sync2 & ~prev, and held until W1C.

Timer:
- When EN = 1, TCOUNT increments every cycle and wraps modulo 2^CNT_W.
- When TCOUNT == TCMP with EN = 1, IPEND[5] is set. If PER = 1, TCOUNT becomes 0 on the next cycle instead of TCMP+1.

Output:
- int_o <= IPEND & IMASK, registered.

Priorities for simultaneous events:
- Hardware set beats a W1C clear on the same bit in the same cycle.
- A bus write to TCOUNT beats increment and reload.
- A TCMP write clear beats a timer match in the same cycle; the new TCMP applies from the next cycle.

Mode change: changing IMODE from level to edge leaves pend at its current value. Changing from edge to level lets pend follow sync2 from the next cycle.

## Timing
- Reset values: all registers, sync flops, int_o, bus_rdata and bus_ack are 0.
- Reset is asynchronous: mid-operation it drops int_o and any in-flight ack immediately.
- External latency: irq_raw rising ahead of edge E1 sets pend at E3 and raises int_o at E4 (4 cycles). Deassertion of a level line follows the same 4 cycles.
- Timer latency: match detected in cycle C sets IPEND[5] at the end of C; int_o[5] is high in C+2.
- Bus handshake:
  - bus_req is sampled at edge E.
  - A write takes effect at E.
  - At E+1, bus_ack = 1 for one cycle, and for reads bus_rdata holds the value of the register as it was before E.
  - bus_rdata holds its value until the next read.
  - bus_req asserted while bus_ack = 1 is accepted; there is no back-pressure.
- A mask change reaches int_o one cycle after the write edge.

## Structure
- Shared package `int_ctrl_pkg`:
  - register index constants (IMASK..TCTRL)
  - TCTRL bit positions EN and PER
  - timer line index 5
  - W_INT = 6
- Sub-module `irq_sync`:
  - instantiated N_EXT times
  - contains the 2-flop synchronizer plus prev flop
  - outputs `lvl` (sync2) and `rise` (sync2 & ~prev)
- Pending, mask, timer and bus decode stay in `int_ctrl`.

## Test plan
- **Reset:** assert rst_ low mid-cycle with int_o = 6'h01 → int_o, bus_ack and bus_rdata are 0 immediately; reading IMASK after release returns 0.
- **Level line:** IMASK = 6'h3F, IMODE = 0; raise irq_raw[2] → int_o = 6'h04 four cycles later. Drop it → int_o = 0 four cycles later. W1C on bit 2 while the line is high has no effect.
- **Edge line:** IMODE[0] = 1; pulse irq_raw[0] high for 3 cycles → IPEND = 6'h01 sticky. Write IPEND = 6'h01 → cleared. Issue W1C on the same cycle as a new rise → the bit stays 1.
- **Timer, one-shot:** TCMP = 10, TCOUNT = 0, TCTRL = 1 → IPEND[5] set in the match cycle, and TCOUNT reads 11 and beyond afterwards. Write TCMP → IPEND[5] = 0.
- **Timer, periodic:** TCTRL = 3, TCMP = 4 → TCOUNT runs 0..4,0.., with a match every 5 cycles. Set TCOUNT = 32'hFFFF_FFFF with PER = 0 and TCMP = 2 → wraps to 0, matches 3 cycles later.
- **Bus:** read addr 6 → ack next cycle with rdata = 0. Read IMASK in the same cycle as writing it → returns the old value; the next read returns the new value.
